l1_threshold_servo: RTL

L1_THRESHOLD_SERVO -- requirements
Module: l1_threshold_servo

---
 rtl/l1_threshold_servo.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/l1_threshold_servo.sv
// L1 trigger-rate threshold servo: counts per-beam triggers over a window and nudges each threshold toward target.
// Optional scaler readback is built when L1_SERVO_READBACK_EN is defined.
module l1_threshold_servo #(
    parameter int NBEAMS         = 2,
    parameter int THRESH_BITS    = 18,
    parameter int COUNT_BITS     = 24,
    parameter int PERIOD_CLOCKS  = 1000,
    parameter int HOLDOFF_CLOCKS = 16,
    parameter int STEP           = 1
) (
    input  logic                   ifclk,
    input  logic                   ifclk_rst_i,
    input  logic                   enable_i,
    input  logic                   thresh_load_i,
    input  logic [THRESH_BITS-1:0] init_thresh_i,
    input  logic [COUNT_BITS-1:0]  target_i,
    input  logic [COUNT_BITS-1:0]  delta_i,
    input  logic [NBEAMS-1:0]      trigger_i,
    output logic [THRESH_BITS-1:0] thresh_o,
    output logic [NBEAMS-1:0]      thresh_ce_o,
    output logic                   update_o,
    output logic                   period_done_o,
    input  logic [5:0]             beam_idx_i,
    output logic [COUNT_BITS-1:0]  scal_dat_o
);

    localparam int IB = (NBEAMS > 1) ? $clog2(NBEAMS) : 1;
    localparam int PB = $clog2(PERIOD_CLOCKS);
    localparam int HB = (HOLDOFF_CLOCKS > 1) ? $clog2(HOLDOFF_CLOCKS) : 1;
    localparam logic [IB-1:0]          LAST_BEAM = IB'(NBEAMS - 1);
    localparam logic [PB-1:0]          LAST_TICK = PB'(PERIOD_CLOCKS - 1);
    localparam logic [HB-1:0]          HOLD_INIT = HB'(HOLDOFF_CLOCKS - 1);
    localparam logic [THRESH_BITS-1:0] THR_MAX   = '1;
    localparam logic [COUNT_BITS-1:0]  CNT_MAX   = '1;
    localparam logic [THRESH_BITS:0]   STEP_W    = (THRESH_BITS + 1)'(STEP);

    typedef enum logic [2:0] {
        S_IDLE, S_COUNT, S_ADJUST, S_UPDATE, S_LOAD, S_LOAD_UPD
    } state_t;

    state_t                 state_q, state_d;
    logic [PB-1:0]          tick_q, tick_d;
    logic [IB-1:0]          idx_q, idx_d;
    logic [COUNT_BITS-1:0]  count_q [NBEAMS];
    logic [COUNT_BITS-1:0]  count_d [NBEAMS];
    logic [HB-1:0]          hold_q [NBEAMS];
    logic [HB-1:0]          hold_d [NBEAMS];
    logic [THRESH_BITS-1:0] thr_q [NBEAMS];
    logic [THRESH_BITS-1:0] thr_d [NBEAMS];
    logic [THRESH_BITS-1:0] tout_q, tout_d;
    logic [NBEAMS-1:0]      ce_q, ce_d;
    logic                   upd_q, upd_d;
    logic                   pdone_q, pdone_d;
    logic                   sweep;
`ifdef L1_SERVO_READBACK_EN
    logic [COUNT_BITS-1:0]  lat_q [NBEAMS];
    logic [COUNT_BITS-1:0]  lat_d [NBEAMS];
    logic [COUNT_BITS-1:0]  scal_q, scal_d;
`endif

    function automatic logic [THRESH_BITS-1:0] adjust(input logic [THRESH_BITS-1:0] thr,
                                                      input logic [COUNT_BITS-1:0]  cnt);
        logic [COUNT_BITS:0]    hi;
        logic [COUNT_BITS:0]    lo;
        logic [THRESH_BITS:0]   up;
        logic [THRESH_BITS-1:0] res;
        hi  = {1'b0, target_i} + {1'b0, delta_i};
        lo  = (delta_i > target_i) ? '0 : ({1'b0, target_i} - {1'b0, delta_i});
        up  = {1'b0, thr} + STEP_W;
        res = thr;
        if ({1'b0, cnt} > hi)
            res = (up > {1'b0, THR_MAX}) ? THR_MAX : up[THRESH_BITS-1:0];
        else if ({1'b0, cnt} < lo)
            res = ({1'b0, thr} < STEP_W) ? '0 : (thr - STEP_W[THRESH_BITS-1:0]);
        return res;
    endfunction

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        idx_d   = idx_q;
        count_d = count_q;
        hold_d  = hold_q;
        thr_d   = thr_q;
        tout_d  = tout_q;
        ce_d    = '0;
        upd_d   = 1'b0;
        pdone_d = 1'b0;
        sweep   = 1'b0;
`ifdef L1_SERVO_READBACK_EN
        lat_d   = lat_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (thresh_load_i) begin
                    for (int unsigned b = 0; b < NBEAMS; b++) thr_d[b] = init_thresh_i;
                    state_d = S_LOAD;
                    idx_d   = '0;
                    sweep   = 1'b1;
                end else if (enable_i) begin
                    state_d = S_COUNT;
                    tick_d  = '0;
                end
            end
            S_COUNT: begin
                for (int unsigned b = 0; b < NBEAMS; b++) begin
                    if (hold_q[b] != '0) begin
                        hold_d[b] = hold_q[b] - 1'b1;
                    end else if (trigger_i[b]) begin
                        hold_d[b] = HOLD_INIT;
                        if (count_q[b] != CNT_MAX) count_d[b] = count_q[b] + 1'b1;
                    end
                end
                if (tick_q == LAST_TICK) begin
                    // All beams are decided at window close; the sweep then just presents them in order.
                    for (int unsigned b = 0; b < NBEAMS; b++) begin
`ifdef L1_SERVO_READBACK_EN
                        lat_d[b] = count_d[b];
`endif
                        thr_d[b]   = adjust(thr_q[b], count_d[b]);
                        count_d[b] = '0;
                        hold_d[b]  = '0;
                    end
                    state_d = S_ADJUST;
                    idx_d   = '0;
                    sweep   = 1'b1;
                    pdone_d = 1'b1;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            S_ADJUST, S_LOAD: begin
                if (idx_q == LAST_BEAM) begin
                    state_d = (state_q == S_ADJUST) ? S_UPDATE : S_LOAD_UPD;
                    upd_d   = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                    sweep = 1'b1;
                end
            end
            S_UPDATE: begin
                state_d = S_COUNT;
                tick_d  = '0;
            end
            S_LOAD_UPD: state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase

        // The load sweep belongs to IDLE, so only the servo states are torn down by enable_i low.
        if (!enable_i && (state_q == S_COUNT || state_q == S_ADJUST || state_q == S_UPDATE)) begin
            state_d = S_IDLE;
            thr_d   = thr_q;
            sweep   = 1'b0;
            upd_d   = 1'b0;
            pdone_d = 1'b0;
`ifdef L1_SERVO_READBACK_EN
            lat_d   = lat_q;
`endif
            for (int unsigned b = 0; b < NBEAMS; b++) begin
                count_d[b] = '0;
                hold_d[b]  = '0;
            end
        end

        if (sweep) begin
            tout_d = thr_d[idx_d];
            ce_d   = NBEAMS'(1) << idx_d;
        end
    end

    always_ff @(posedge ifclk or posedge ifclk_rst_i) begin
        if (ifclk_rst_i) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            idx_q   <= '0;
            tout_q  <= '0;
            ce_q    <= '0;
            upd_q   <= 1'b0;
            pdone_q <= 1'b0;
            for (int unsigned b = 0; b < NBEAMS; b++) begin
                count_q[b] <= '0;
                hold_q[b]  <= '0;
                thr_q[b]   <= '0;
`ifdef L1_SERVO_READBACK_EN
                lat_q[b]   <= '0;
`endif
            end
`ifdef L1_SERVO_READBACK_EN
            scal_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            idx_q   <= idx_d;
            tout_q  <= tout_d;
            ce_q    <= ce_d;
            upd_q   <= upd_d;
            pdone_q <= pdone_d;
            count_q <= count_d;
            hold_q  <= hold_d;
            thr_q   <= thr_d;
`ifdef L1_SERVO_READBACK_EN
            lat_q   <= lat_d;
            scal_q  <= scal_d;
`endif
        end
    end

`ifdef L1_SERVO_READBACK_EN
    always_comb begin
        scal_d = '0;
        for (int unsigned b = 0; b < NBEAMS; b++)
            if (beam_idx_i == 6'(b)) scal_d = lat_q[b];
    end
    assign scal_dat_o = scal_q;
`else
    logic unused_beam_idx;
    assign unused_beam_idx = ^beam_idx_i;
    assign scal_dat_o      = '0;
`endif

    assign thresh_o      = tout_q;
    assign thresh_ce_o   = ce_q;
    assign update_o      = upd_q;
    assign period_done_o = pdone_q;

endmodule
